// File: rtl/rssb_serial_mem.sv
// rtl/rssb_serial_mem.sv - bit-serial operand memory for the 1-bit RSSB cpu data port
// Optional RSSB_SMEM_ZFLAG_EN adds a registered zero flag for the captured word.
module rssb_serial_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic             bit_en,
  input  logic             din,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
`ifdef RSSB_SMEM_ZFLAG_EN
  output logic             zero,
`endif
  output logic             dout,
  output logic             busy,
  output logic             last,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PEN_CNT  = CW'(WIDTH - 2);
  localparam logic [AW:0]   DEPTH_L  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, WRITE} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] rd_word;
  logic [AW-1:0]    addr_q;
  logic             we_q;
  logic [CW-1:0]    cnt;
  logic             addr_ok;
  logic             ld_ok;

  // Out-of-range addresses only exist when DEPTH is not a power of two.
  assign addr_ok = {1'b0, addr_q} < DEPTH_L;
  assign ld_ok   = {1'b0, ld_addr} < DEPTH_L;
  assign rd_word = addr_ok ? mem[addr_q] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      shreg  <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      dout   <= 1'b0;
      busy   <= 1'b0;
      last   <= 1'b0;
      done   <= 1'b0;
`ifdef RSSB_SMEM_ZFLAG_EN
      zero   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_en) begin
            if (ld_ok) mem[ld_addr] <= ld_data;
          end else if (req) begin
            addr_q <= addr;
            we_q   <= we;
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          shreg <= rd_word;
          cnt   <= '0;
          dout  <= rd_word[0];
          state <= SHIFT;
        end
        SHIFT: begin
          if (bit_en) begin
            shreg <= {din, shreg[WIDTH-1:1]};
            cnt   <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
              dout  <= 1'b0;
              last  <= 1'b0;
              done  <= 1'b1;
              state <= WRITE;
            end else begin
              // Registered dout follows what shreg[0] becomes after this shift.
              dout <= shreg[1];
              last <= (cnt == PEN_CNT);
            end
          end
        end
        WRITE: begin
          if (we_q && addr_ok) mem[addr_q] <= shreg;
`ifdef RSSB_SMEM_ZFLAG_EN
          zero  <= (shreg == '0);
`endif
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rssb_serial_mem.sv
// tb/tb_rssb_serial_mem.sv - directed table and sequence bench for rssb_serial_mem
// Checks the zero flag when RSSB_SMEM_ZFLAG_EN is defined.
module tb_rssb_serial_mem;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req = 1'b0;
  logic       we = 1'b0;
  logic [3:0] addr = '0;
  logic       bit_en = 1'b0;
  logic       din = 1'b0;
  logic       ld_en = 1'b0;
  logic [3:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  logic       dout, busy, last, done;
  logic       zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rssb_serial_mem #(.WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr),
    .bit_en(bit_en), .din(din), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
`ifdef RSSB_SMEM_ZFLAG_EN
    .zero(zero),
`endif
    .dout(dout), .busy(busy), .last(last), .done(done)
  );

`ifndef RSSB_SMEM_ZFLAG_EN
  assign zero = 1'b0;
`endif

  typedef struct {
    logic       rst, req, we;
    logic [3:0] addr;
    logic       bit_en, din, ld_en;
    logic [3:0] ld_addr;
    logic [7:0] ld_data;
    logic [3:0] exp;  // {dout, busy, last, done}
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic [2:0] rrw, input logic [3:0] a, input logic [2:0] bdl,
                              input logic [3:0] la, input logic [7:0] ld, input logic [3:0] e);
    vec_t v;
    {v.rst, v.req, v.we} = rrw;
    v.addr = a;
    {v.bit_en, v.din, v.ld_en} = bdl;
    v.ld_addr = la;
    v.ld_data = ld;
    v.exp = e;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic txn(input logic [3:0] a, input logic w, input logic [7:0] dw,
                     input int maxgap, input logic [7:0] exp_rd);
    req = 1'b1; addr = a; we = w;
    tick();
    req = 1'b0; we = 1'b0;
    chk("txn_load_busy", {31'b0, busy}, 1);
    tick();
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < i % (maxgap + 1); g++) begin
        tick();
        chk("txn_hold_dout", {31'b0, dout}, {31'b0, exp_rd[i]});
      end
      chk("txn_dout", {31'b0, dout}, {31'b0, exp_rd[i]});
      chk("txn_last", {31'b0, last}, (i == 7) ? 1 : 0);
      bit_en = 1'b1; din = dw[i];
      tick();
      bit_en = 1'b0; din = 1'b0;
    end
    chk("txn_done_hi", {30'b0, done, dout}, 32'h2);
    tick();
    chk("txn_done_lo", {30'b0, done, busy}, 0);
`ifdef RSSB_SMEM_ZFLAG_EN
    chk("txn_zero", {31'b0, zero}, (dw == 8'h00) ? 1 : 0);
`endif
  endtask

  initial begin
    // rst,req,we | addr | bit_en,din,ld_en | ld_addr | ld_data | dout,busy,last,done
    vecs[0]  = mk(3'b000, 4'd0, 3'b000, 4'd0, 8'h00, 4'b0000);
    vecs[1]  = mk(3'b100, 4'd0, 3'b001, 4'd3, 8'hA5, 4'b0000);
    vecs[2]  = mk(3'b110, 4'd3, 3'b000, 4'd0, 8'h00, 4'b0100);
    vecs[3]  = mk(3'b100, 4'd0, 3'b100, 4'd0, 8'h00, 4'b1100);
    vecs[4]  = mk(3'b100, 4'd0, 3'b000, 4'd0, 8'h00, 4'b1100);
    vecs[5]  = mk(3'b111, 4'd3, 3'b101, 4'd3, 8'hFF, 4'b0100);
    vecs[6]  = mk(3'b100, 4'd0, 3'b100, 4'd0, 8'h00, 4'b1100);
    vecs[7]  = mk(3'b100, 4'd0, 3'b100, 4'd0, 8'h00, 4'b0100);
    vecs[8]  = mk(3'b100, 4'd0, 3'b100, 4'd0, 8'h00, 4'b0100);
    vecs[9]  = mk(3'b100, 4'd0, 3'b100, 4'd0, 8'h00, 4'b1100);
    vecs[10] = mk(3'b100, 4'd0, 3'b100, 4'd0, 8'h00, 4'b0100);
    vecs[11] = mk(3'b100, 4'd0, 3'b100, 4'd0, 8'h00, 4'b1110);
    vecs[12] = mk(3'b110, 4'd3, 3'b100, 4'd0, 8'h00, 4'b0101);
    vecs[13] = mk(3'b110, 4'd3, 3'b000, 4'd0, 8'h00, 4'b0000);
    vecs[14] = mk(3'b100, 4'd0, 3'b000, 4'd0, 8'h00, 4'b0000);

    rst = 1'b0;
    tick();
    chk("reset_zero", {31'b0, zero}, 0);
    chk("reset_outs", {28'b0, dout, busy, last, done}, 0);

    for (int i = 0; i < 15; i++) begin
      rst = vecs[i].rst; req = vecs[i].req; we = vecs[i].we; addr = vecs[i].addr;
      bit_en = vecs[i].bit_en; din = vecs[i].din; ld_en = vecs[i].ld_en;
      ld_addr = vecs[i].ld_addr; ld_data = vecs[i].ld_data;
      tick();
      chk($sformatf("row%0d_dout", i), {31'b0, dout}, {31'b0, vecs[i].exp[3]});
      chk($sformatf("row%0d_busy", i), {31'b0, busy}, {31'b0, vecs[i].exp[2]});
      chk($sformatf("row%0d_last", i), {31'b0, last}, {31'b0, vecs[i].exp[1]});
      chk($sformatf("row%0d_done", i), {31'b0, done}, {31'b0, vecs[i].exp[0]});
    end
    req = 1'b0; we = 1'b0; bit_en = 1'b0; ld_en = 1'b0;

    txn(4'd3, 1'b1, 8'h03, 0, 8'hA5);
    txn(4'd3, 1'b1, 8'hC6, 3, 8'h03);
    txn(4'd3, 1'b0, 8'h00, 0, 8'hC6);
    txn(4'd3, 1'b1, 8'h81, 2, 8'hC6);

    ld_en = 1'b1; ld_addr = 4'd7; ld_data = 8'h5A; req = 1'b1; addr = 4'd7; we = 1'b1;
    tick();
    ld_en = 1'b0; req = 1'b0; we = 1'b0;
    chk("collide_busy0", {31'b0, busy}, 0);
    tick();
    chk("collide_busy1", {30'b0, busy, done}, 0);
    txn(4'd7, 1'b0, 8'h00, 0, 8'h5A);

    txn(4'd3, 1'b0, 8'h00, 0, 8'h81);

    ld_en = 1'b1; ld_addr = 4'd5; ld_data = 8'h3C;
    tick();
    ld_en = 1'b0;
    req = 1'b1; addr = 4'd5; we = 1'b1;
    tick();
    req = 1'b0; we = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      bit_en = 1'b1; din = 1'b1;
      tick();
    end
    bit_en = 1'b0; din = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_outs", {28'b0, dout, busy, last, done}, 0);
    chk("midrst_zero", {31'b0, zero}, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_nodone", {30'b0, busy, done}, 0);
    end
    txn(4'd5, 1'b0, 8'h00, 0, 8'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
